// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one Sdram_Ctrl processor port among NUM_PORTS requesters.
// Optional WAIT-state watchdog is compiled in when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
  output logic [NUM_PORTS-1:0]            ack_o,
  output logic [NUM_PORTS-1:0]            err_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            mem_we_o,
  output logic                            mem_re_o,
  input  logic [DATA_WIDTH-1:0]           mem_data_i,
  input  logic                            mem_ack_i,
  input  logic                            mem_busy_i,
  output logic [1:0]                      dbg_state_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          last_gnt_q, last_gnt_d;
  logic                   we_q, we_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic                   mem_we_q, mem_we_d;
  logic                   mem_re_q, mem_re_d;
  logic                   win_found;
  logic [PW-1:0]          win_idx;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
`endif

  // Rotating priority: search starts one past the most recent grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_gnt_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      int idx;
      idx = (int'(last_gnt_q) + i) % NUM_PORTS;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    ack_d      = '0;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          last_gnt_d = win_idx;
          we_d       = we_i[win_idx];
          mem_addr_d = addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_data_d = data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The strobe is only launched from a cycle in which the controller reported idle.
        if (!mem_busy_i) begin
          mem_we_d = we_q;
          mem_re_d = !we_q;
          state_d  = S_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          ack_d[last_gnt_q] = 1'b1;
          if (!we_q) data_d = mem_data_i;
          state_d = S_DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          ack_d[last_gnt_q] = 1'b1;
          err_d[last_gnt_q] = 1'b1;
          data_d  = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      last_gnt_q <= PW'(NUM_PORTS - 1);
      we_q       <= 1'b0;
      ack_q      <= '0;
      data_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = '0;
`endif

  assign ack_o       = ack_q;
  assign data_o      = data_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: requester drivers, an SDRAM controller model and
// scoreboards for the memory strobes and the per-port acknowledges.
module tb_sdram_port_arbiter;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic [NP-1:0]     req_i, we_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW-1:0]  data_i;
  logic [NP-1:0]     ack_o, err_o;
  logic [DW-1:0]     data_o, mem_data_o, mem_data_i;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_we_o, mem_re_o, mem_ack_i, mem_busy_i;
  logic [1:0]        dbg_state_o;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .err_o(err_o),
    .data_o(data_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .mem_busy_i(mem_busy_i), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] strb_q[$];
  logic [31:0]  sdram[logic [31:0]];
  logic [31:0]  last_rd = '0;

  int  cyc = 0;
  int  lat = 4;
  bit  model_ack_en = 1'b1;
  int  strobe_cnt = 0;
  int  strobe_cyc = 0;
  int  ack_cyc = 0;
  bit  pending = 1'b0;
  bit  pend_we = 1'b0;
  bit  ack_given = 1'b0;
  bit  prev_strobe = 1'b0;
  int  pend_cnt = 0;
  logic [31:0] pend_addr, pend_data;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (sdram.exists(a)) return sdram[a];
    return ~a;
  endfunction

  function automatic logic [127:0] ack_exp(input int p, input bit err, input logic [31:0] d);
    logic [1:0] a;
    a = '0;
    a[p] = 1'b1;
    return {92'b0, a, (err ? a : 2'b00), d};
  endfunction

  // Reads expect the memory word; writes expect data_o to keep the last read value.
  task automatic push_op(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    strb_q.push_back({63'b0, we, a, d});
    if (!we) last_rd = rd_word(a);
    exp_q.push_back(ack_exp(p, 1'b0, last_rd));
  endtask

  task automatic req_start(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    we_i[p]          = we;
    addr_i[p*AW +: AW] = a;
    data_i[p*DW +: DW] = d;
    req_i[p]         = 1'b1;
  endtask

  task automatic req_wait(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_o[p] && n < 2000);
    if (n >= 2000) check("ack_timeout", 0, 1);
    req_i[p] = 1'b0;
  endtask

  // SDRAM controller model plus ack monitor, evaluated once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ack_given) check("ack_latency", |ack_o, 1);
      ack_given = 1'b0;
      mem_ack_i = 1'b0;
      if (sys_rst) begin
        pending = 1'b0;
      end else if (pending) begin
        if (pend_cnt == 0) begin
          mem_ack_i  = 1'b1;
          ack_given  = 1'b1;
          mem_data_i = pend_we ? 32'hBAD0_BAD0 : rd_word(pend_addr);
          if (pend_we) sdram[pend_addr] = pend_data;
          pending = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_re_o || mem_we_o) begin
        strobe_cnt++;
        strobe_cyc = cyc;
        check("strobe_width", prev_strobe, 0);
        check("strobe_both", mem_re_o & mem_we_o, 0);
        if (strb_q.size() == 0) check("strobe_unexpected", 1, 0);
        else check("strobe", {mem_we_o, mem_addr_o, mem_data_o}, strb_q.pop_front());
        if (model_ack_en) begin
          pending   = 1'b1;
          pend_cnt  = lat - 1;
          pend_we   = mem_we_o;
          pend_addr = mem_addr_o;
          pend_data = mem_data_o;
        end
      end
      prev_strobe = mem_re_o | mem_we_o;
      if (|ack_o) begin
        ack_cyc = cyc;
        check("ack_onehot", $onehot(ack_o), 1);
        if (exp_q.size() == 0) check("ack_unexpected", {ack_o, err_o, data_o}, 0);
        else check("ack", {ack_o, err_o, data_o}, exp_q.pop_front());
      end else if (|err_o) begin
        check("err_without_ack", err_o, 0);
      end
    end
  end

  initial begin
    sys_rst    = 1'b1;
    req_i      = '0;
    we_i       = '0;
    addr_i     = '0;
    data_i     = '0;
    mem_data_i = '0;
    mem_ack_i  = 1'b0;
    mem_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ack_o, err_o, data_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o}, 0);
    check("reset_state", dbg_state_o, 0);
    sys_rst = 1'b0;
    @(negedge clk);

    // Port 0 read, slow memory; strobe appears two cycles after the request.
    sdram[32'h10] = 32'h0000_ABCD;
    lat = 8;
    push_op(0, 1'b0, 32'h10, 32'h0);
    req_start(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("strobe_early", mem_re_o, 0);
    @(negedge clk);
    check("strobe_latency", mem_re_o, 1);
    req_wait(0);
    check("read_data", data_o, 32'h0000_ABCD);

    // Port 1 write; data_o must keep the previous read value.
    lat = 3;
    push_op(1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    req_start(1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    req_wait(1);
    check("write_data_hold", data_o, 32'h0000_ABCD);

    // Both ports request back to back: grants must alternate 0,1,0,1,0,1.
    for (int k = 0; k < 3; k++) begin
      push_op(0, 1'b0, 32'h100 + 32'(k * 8), 32'h0);
      push_op(1, 1'b0, 32'h104 + 32'(k * 8), 32'h0);
    end
    fork
      for (int k = 0; k < 3; k++) begin
        req_start(0, 1'b0, 32'h100 + 32'(k * 8), 32'h0);
        req_wait(0);
      end
      for (int k = 0; k < 3; k++) begin
        req_start(1, 1'b0, 32'h104 + 32'(k * 8), 32'h0);
        req_wait(1);
      end
    join

    // Controller busy for 20 cycles while a request sits in ISSUE.
    begin
      int s0;
      s0 = strobe_cnt;
      mem_busy_i = 1'b1;
      push_op(0, 1'b0, 32'h30, 32'h0);
      req_start(0, 1'b0, 32'h30, 32'h0);
      repeat (20) @(negedge clk);
      check("busy_no_strobe", strobe_cnt - s0, 0);
      check("busy_state", dbg_state_o, 1);
      mem_busy_i = 1'b0;
      req_wait(0);
      check("busy_one_strobe", strobe_cnt - s0, 1);
    end

    // Reset while waiting on the controller: everything clears at once, no ack.
    begin
      int n;
      model_ack_en = 1'b0;
      strb_q.push_back({63'b0, 1'b0, 32'h40, 32'h0});
      req_start(0, 1'b0, 32'h40, 32'h0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dbg_state_o != 2'd2 && n < 50);
      check("reach_wait", dbg_state_o, 2);
      repeat (3) @(negedge clk);
      sys_rst = 1'b1;
      #1;
      check("rst_mid_outputs", {ack_o, err_o, data_o, mem_addr_o, mem_data_o, mem_we_o, mem_re_o}, 0);
      check("rst_mid_state", dbg_state_o, 0);
      req_i = '0;
      last_rd = '0;
      @(negedge clk);
      sys_rst = 1'b0;
      model_ack_en = 1'b1;
      @(negedge clk);
      push_op(0, 1'b0, 32'h44, 32'h0);
      push_op(1, 1'b0, 32'h48, 32'h0);
      fork
        begin req_start(0, 1'b0, 32'h44, 32'h0); req_wait(0); end
        begin req_start(1, 1'b0, 32'h48, 32'h0); req_wait(1); end
      join
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Controller never answers: watchdog acks with err after TO cycles in WAIT.
    model_ack_en = 1'b0;
    strb_q.push_back({63'b0, 1'b0, 32'h50, 32'h0});
    exp_q.push_back(ack_exp(1, 1'b1, 32'h0));
    last_rd = '0;
    req_start(1, 1'b0, 32'h50, 32'h0);
    req_wait(1);
    check("timeout_latency", ack_cyc - strobe_cyc, TO);
    check("timeout_data", data_o, 0);
    model_ack_en = 1'b1;
    @(negedge clk);
`endif

    // Random single-port traffic with random latency and busy.
    for (int k = 0; k < 10; k++) begin
      int p;
      bit we;
      logic [31:0] a, d;
      p  = $urandom_range(0, NP - 1);
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 7)) << 2;
      d  = $urandom;
      lat = $urandom_range(1, 10);
      mem_busy_i = 1'($urandom_range(0, 1));
      push_op(p, we, a, d);
      req_start(p, we, a, d);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      mem_busy_i = 1'b0;
      req_wait(p);
    end

    repeat (5) @(negedge clk);
    check("ack_queue_empty", exp_q.size(), 0);
    check("strobe_queue_empty", strb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
